// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit with req/ack data-memory handshake
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              mem_to_reg,
  input  logic              mem_write,
  input  logic [2:0]        load_type,
  input  logic [1:0]        store_type,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       wdata_in,
  input  logic [4:0]        rd_in,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              misalign
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic              op, aligned, accept;
  logic [1:0]        size;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d, ext_data;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q, wb_data_q;
  logic [2:0]        lt_q;
  logic [1:0]        off_q;
  logic [4:0]        rd_q, wb_rd_q;
  logic              wb_valid_q, misalign_q;

  // size: 0 byte, 1 half, 2 word; a store wins when both decode bits are set
  always_comb begin
    op = req_valid & (mem_to_reg | mem_write);
    if (mem_write) begin
      case (store_type)
        2'd0:    size = 2'd0;
        2'd1:    size = 2'd1;
        default: size = 2'd2;
      endcase
    end else begin
      case (load_type)
        3'd0, 3'd1: size = 2'd0;
        3'd2, 3'd3: size = 2'd1;
        default:    size = 2'd2;
      endcase
    end
    case (size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~addr_in[0];
      default: aligned = (addr_in[1:0] == 2'b00);
    endcase
    accept = (state_q == IDLE) & op & aligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (dmem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall = rst_n & ((state_q == IDLE) ? accept : ~dmem_ack);
    be_d    = 4'b1111;
    wdata_d = wdata_in;
    if (mem_write) begin
      case (size)
        2'd0: begin
          be_d    = 4'b0001 << addr_in[1:0];
          wdata_d = {4{wdata_in[7:0]}};
        end
        2'd1: begin
          be_d    = addr_in[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{wdata_in[15:0]}};
        end
        default: ;
      endcase
    end
    case (off_q)
      2'd0:    rbyte = dmem_rdata[7:0];
      2'd1:    rbyte = dmem_rdata[15:8];
      2'd2:    rbyte = dmem_rdata[23:16];
      default: rbyte = dmem_rdata[31:24];
    endcase
    rhalf = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (lt_q)
      3'd0:    ext_data = {{24{rbyte[7]}}, rbyte};
      3'd1:    ext_data = {24'd0, rbyte};
      3'd2:    ext_data = {{16{rhalf[15]}}, rhalf};
      3'd3:    ext_data = {16'd0, rhalf};
      default: ext_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'd0;
      lt_q       <= 3'd0;
      off_q      <= 2'd0;
      rd_q       <= 5'd0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'd0;
      wb_rd_q    <= 5'd0;
      misalign_q <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= mem_write;
        addr_q  <= {addr_in[ADDR_W-1:2], 2'b00};
        be_q    <= be_d;
        wdata_q <= wdata_d;
        lt_q    <= load_type;
        off_q   <= addr_in[1:0];
        rd_q    <= rd_in;
      end
      wb_valid_q <= (state_q == BUSY) & dmem_ack & ~we_q;
      if ((state_q == BUSY) & dmem_ack & ~we_q) begin
        wb_data_q <= ext_data;
        wb_rd_q   <= rd_q;
      end
      misalign_q <= (state_q == IDLE) & op & ~aligned;
    end
  end

  assign dmem_req   = (state_q == BUSY);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_rd      = wb_rd_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk, rst_n, req_valid, mem_to_reg, mem_write;
  logic [2:0]  load_type;
  logic [1:0]  store_type;
  logic [31:0] addr_in, wdata_in;
  logic [4:0]  rd_in;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, misalign;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  int tests, fails;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .load_type(load_type), .store_type(store_type),
    .addr_in(addr_in), .wdata_in(wdata_in), .rd_in(rd_in), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = 0; mem_to_reg = 0; mem_write = 0; load_type = 0; store_type = 0;
    addr_in = 0; wdata_in = 0; rd_in = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic drive_load(input logic [2:0] lt, input logic [31:0] a, input logic [4:0] rd);
    req_valid = 1; mem_to_reg = 1; mem_write = 0; load_type = lt; addr_in = a; rd_in = rd;
  endtask

  task automatic drive_store(input logic [1:0] st, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1; mem_to_reg = 0; mem_write = 1; store_type = st; addr_in = a; wdata_in = wd;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    drive_load(3'd4, 32'h0, 5'd1);
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", stall); end
    next_cycle();
    tests++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid, wb_data, wb_rd, misalign} !== '0) begin
      fails++; $display("FAIL reset_outputs got req=%b we=%b addr=%h be=%b wd=%h wbv=%b wbd=%h rd=%0d mis=%b exp all 0",
        dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid, wb_data, wb_rd, misalign);
    end
    clear_inputs();
    rst_n = 1;
    next_cycle();
  endtask

  task automatic test_store_word();
    drive_store(2'd2, 32'h100, 32'hDEADBEEF);
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sw_stall_T got %b exp 1", stall); end
    next_cycle();
    clear_inputs();
    #1;
    tests++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF}) begin
      fails++; $display("FAIL sw_bus got req=%b we=%b addr=%h be=%b wd=%h exp 1 1 00000100 1111 deadbeef",
        dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
    end
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sw_stall_T1 got %b exp 1", stall); end
    next_cycle();
    tests++; if ({dmem_req, stall} !== 2'b11) begin fails++; $display("FAIL sw_T2 got req=%b stall=%b exp 1 1", dmem_req, stall); end
    dmem_ack = 1;
    #1;
    tests++; if ({dmem_req, stall} !== 2'b10) begin fails++; $display("FAIL sw_ack got req=%b stall=%b exp 1 0", dmem_req, stall); end
    next_cycle();
    dmem_ack = 0;
    #1;
    tests++; if ({dmem_req, stall, wb_valid} !== 3'b000) begin fails++; $display("FAIL sw_done got req=%b stall=%b wbv=%b exp 0 0 0", dmem_req, stall, wb_valid); end
    next_cycle();
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL sw_no_wb got %b exp 0", wb_valid); end
  endtask

  task automatic test_store_lanes();
    logic [1:0]  st [3]  = '{2'd1, 2'd0, 2'd3};
    logic [31:0] ad [3]  = '{32'h102, 32'h101, 32'h208};
    logic [31:0] wd [3]  = '{32'h0000ABCD, 32'h12345655, 32'hCAFEF00D};
    logic [31:0] ea [3]  = '{32'h100, 32'h100, 32'h208};
    logic [3:0]  eb [3]  = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] ew [3]  = '{32'hABCDABCD, 32'h55555555, 32'hCAFEF00D};
    for (int i = 0; i < 3; i++) begin
      drive_store(st[i], ad[i], wd[i]);
      next_cycle();
      clear_inputs();
      dmem_ack = 1;
      #1;
      tests++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 1'b1, ea[i], eb[i], ew[i]}) begin
        fails++; $display("FAIL store_lane%0d got req=%b we=%b addr=%h be=%b wd=%h exp 1 1 %h %b %h",
          i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ea[i], eb[i], ew[i]);
      end
      next_cycle();
      dmem_ack = 0;
    end
  endtask

  task automatic test_load_byte();
    logic [2:0]  lt [2] = '{3'd0, 3'd1};
    logic [31:0] ex [2] = '{32'hFFFFFF80, 32'h00000080};
    for (int i = 0; i < 2; i++) begin
      drive_load(lt[i], 32'h103, 5'd7);
      #1;
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lb%0d_stall got %b exp 1", i, stall); end
      next_cycle();
      clear_inputs();
      dmem_ack = 1; dmem_rdata = 32'h80FF1234;
      #1;
      tests++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be, stall} !== {1'b1, 1'b0, 32'h100, 4'b1111, 1'b0}) begin
        fails++; $display("FAIL lb%0d_bus got req=%b we=%b addr=%h be=%b stall=%b exp 1 0 00000100 1111 0",
          i, dmem_req, dmem_we, dmem_addr, dmem_be, stall);
      end
      next_cycle();
      dmem_ack = 0; dmem_rdata = 0;
      #1;
      tests++;
      if ({wb_valid, wb_data, wb_rd} !== {1'b1, ex[i], 5'd7}) begin
        fails++; $display("FAIL lb%0d_wb got v=%b data=%h rd=%0d exp 1 %h 7", i, wb_valid, wb_data, wb_rd, ex[i]);
      end
      next_cycle();
      tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL lb%0d_pulse got %b exp 0", i, wb_valid); end
    end
  endtask

  task automatic test_back_to_back();
    drive_load(3'd2, 32'h002, 5'd3);
    next_cycle();
    clear_inputs();
    dmem_ack = 1; dmem_rdata = 32'h80017FFF;
    next_cycle();
    dmem_ack = 0;
    drive_load(3'd3, 32'h006, 5'd9);
    #1;
    tests++;
    if ({wb_valid, wb_data, wb_rd, stall} !== {1'b1, 32'hFFFF8001, 5'd3, 1'b1}) begin
      fails++; $display("FAIL lh_wb got v=%b data=%h rd=%0d stall=%b exp 1 ffff8001 3 1", wb_valid, wb_data, wb_rd, stall);
    end
    next_cycle();
    clear_inputs();
    dmem_ack = 1; dmem_rdata = 32'h80017FFF;
    #1;
    tests++; if ({dmem_req, dmem_addr} !== {1'b1, 32'h004}) begin fails++; $display("FAIL lhu_bus got req=%b addr=%h exp 1 00000004", dmem_req, dmem_addr); end
    next_cycle();
    dmem_ack = 0;
    #1;
    tests++;
    if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'h00008001, 5'd9}) begin
      fails++; $display("FAIL lhu_hi_wb got v=%b data=%h rd=%0d exp 1 00008001 9", wb_valid, wb_data, wb_rd);
    end
    drive_load(3'd3, 32'h004, 5'd0);
    next_cycle();
    clear_inputs();
    dmem_ack = 1; dmem_rdata = 32'h80017FFF;
    next_cycle();
    dmem_ack = 0;
    #1;
    tests++;
    if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'h00007FFF, 5'd0}) begin
      fails++; $display("FAIL lhu_lo_wb got v=%b data=%h rd=%0d exp 1 00007fff 0", wb_valid, wb_data, wb_rd);
    end
    next_cycle();
  endtask

  task automatic test_misalign();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive_load(3'd4, 32'h101, 5'd4);
      else        drive_store(2'd1, 32'h003, 32'h1111);
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mis%0d_stall got %b exp 0", i, stall); end
      next_cycle();
      clear_inputs();
      #1;
      tests++;
      if ({misalign, dmem_req, stall} !== 3'b100) begin
        fails++; $display("FAIL mis%0d_pulse got mis=%b req=%b stall=%b exp 1 0 0", i, misalign, dmem_req, stall);
      end
      next_cycle();
      tests++; if ({misalign, dmem_req} !== 2'b00) begin fails++; $display("FAIL mis%0d_end got mis=%b req=%b exp 0 0", i, misalign, dmem_req); end
    end
  endtask

  task automatic test_reset_busy();
    drive_load(3'd4, 32'h200, 5'd5);
    next_cycle();
    clear_inputs();
    #1;
    tests++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL rb_busy got req=%b exp 1", dmem_req); end
    rst_n = 0;
    #1;
    tests++; if ({dmem_req, stall} !== 2'b00) begin fails++; $display("FAIL rb_async got req=%b stall=%b exp 0 0", dmem_req, stall); end
    next_cycle();
    rst_n = 1;
    dmem_ack = 1; dmem_rdata = 32'h12345678;
    #1;
    tests++; if ({dmem_req, stall} !== 2'b00) begin fails++; $display("FAIL rb_late_ack got req=%b stall=%b exp 0 0", dmem_req, stall); end
    next_cycle();
    dmem_ack = 0;
    #1;
    tests++; if ({wb_valid, dmem_req, stall} !== 3'b000) begin fails++; $display("FAIL rb_no_wb got v=%b req=%b stall=%b exp 0 0 0", wb_valid, dmem_req, stall); end
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_store_word();
    test_store_lanes();
    test_load_byte();
    test_back_to_back();
    test_misalign();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
